// File: rtl/digit_value_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : digit_value_ctrl_if
// Description : Valid/ready value bus feeding digit_value_ctrl.
//               value_in    - unsigned binary value to display
//               value_valid - source has a value this cycle
//               value_ready - sink can accept (transfer = valid & ready)
//               master modport: value source; slave modport: the controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface digit_value_ctrl_if #(
    parameter int VALUE_W = 14
);
    logic [VALUE_W-1:0] value_in;
    logic               value_valid;
    logic               value_ready;

    modport master (
        output value_in,
        output value_valid,
        input  value_ready
    );

    modport slave (
        input  value_in,
        input  value_valid,
        output value_ready
    );
endinterface
`default_nettype wire

// File: rtl/digit_value_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : digit_value_ctrl
// Description : Accepts a binary value over a valid/ready bus, converts it to
//               BCD with one double-dabble iteration per clock and commits the
//               digits to the display units on the rising edge of vertical
//               blanking so the shown value never changes mid-frame.
// Ports       : clk        - pixel clock, rising edge
//               rst        - asynchronous active-high reset
//               vbus       - value bus (slave side: value_in/valid/ready)
//               vblnk_in   - vertical blanking from the timing chain
//               digits_out - BCD digits, bits [4k+3:4k] are digit k
//               digit_en   - per-digit display enable (leading-zero blanking)
//               busy       - conversion or commit pending
//               commit     - one-cycle pulse when digits_out updates
// Revision    : 1.0 - initial release
// ============================================================================
module digit_value_ctrl #(
    parameter int DIGITS  = 4,
    parameter int VALUE_W = 14
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    digit_value_ctrl_if.slave          vbus,
    input  wire logic                  vblnk_in,
    output logic [4*DIGITS-1:0]        digits_out,
    output logic [DIGITS-1:0]          digit_en,
    output logic                       busy,
    output logic                       commit
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int WORK_W = BCD_W + VALUE_W;
    localparam int CNT_W  = (VALUE_W < 2) ? 1 : $clog2(VALUE_W + 1);

    function automatic logic [31:0] pow10_minus1(input int n);
        logic [31:0] p;
        p = 32'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 32'd10;
        end
        return p - 32'd1;
    endfunction

    localparam logic [31:0] MAX_DEC   = pow10_minus1(DIGITS);
    // Clamp only when the all-nines value fits in the input width; otherwise
    // every input is already displayable (or the caller accepts truncation).
    localparam bit          SATURATE  = (MAX_DEC < (32'd1 << VALUE_W));
    localparam logic [CNT_W-1:0] c_last_iter = CNT_W'(VALUE_W - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONV    = 2'd1,
        S_WAIT_VB = 2'd2
    } state_t;

    state_t              r_state;
    logic [WORK_W-1:0]   r_work;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_vblnk_d;

    logic [VALUE_W-1:0]  w_loaded;
    logic [WORK_W-1:0]   w_adj;
    logic [WORK_W-1:0]   w_shift;
    logic [BCD_W-1:0]    w_bcd;
    logic [DIGITS-1:0]   w_en;
    logic                w_any;
    logic                w_vb_rise;

    // Saturating load value.
    always_comb begin
        w_loaded = vbus.value_in;
        if (SATURATE && (32'(vbus.value_in) > MAX_DEC)) begin
            w_loaded = MAX_DEC[VALUE_W-1:0];
        end
    end

    // One double-dabble step: add 3 to each BCD nibble >= 5, then shift left.
    always_comb begin
        w_adj = r_work;
        for (int k = 0; k < DIGITS; k++) begin
            if (r_work[VALUE_W + 4*k +: 4] >= 4'd5) begin
                w_adj[VALUE_W + 4*k +: 4] = r_work[VALUE_W + 4*k +: 4] + 4'd3;
            end
        end
        w_shift = {w_adj[WORK_W-2:0], 1'b0};
    end

    assign w_bcd = r_work[WORK_W-1 -: BCD_W];

    // Digit k is shown when it or any more significant digit is nonzero;
    // digit 0 is always shown so a zero value still displays "0".
    always_comb begin
        w_any = 1'b0;
        w_en  = '0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            w_any   = w_any | (w_bcd[4*k +: 4] != 4'd0);
            w_en[k] = w_any;
        end
        w_en[0] = 1'b1;
    end

    assign w_vb_rise = vblnk_in & ~r_vblnk_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_work           <= '0;
            r_cnt            <= '0;
            r_vblnk_d        <= 1'b0;
            vbus.value_ready <= 1'b1;
            busy             <= 1'b0;
            commit           <= 1'b0;
            digits_out       <= '0;
            digit_en         <= DIGITS'(1);
        end else begin
            r_vblnk_d <= vblnk_in;
            commit    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (vbus.value_valid && vbus.value_ready) begin
                        r_work           <= {{BCD_W{1'b0}}, w_loaded};
                        r_cnt            <= '0;
                        r_state          <= S_CONV;
                        vbus.value_ready <= 1'b0;
                        busy             <= 1'b1;
                    end
                end
                S_CONV: begin
                    r_work <= w_shift;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == c_last_iter) begin
                        r_state <= S_WAIT_VB;
                    end
                end
                S_WAIT_VB: begin
                    // Edges seen before this state are deliberately not kept;
                    // the commit always lands on a fresh blanking edge.
                    if (w_vb_rise) begin
                        digits_out       <= w_bcd;
                        digit_en         <= w_en;
                        commit           <= 1'b1;
                        r_state          <= S_IDLE;
                        vbus.value_ready <= 1'b1;
                        busy             <= 1'b0;
                    end
                end
                default: begin
                    r_state          <= S_IDLE;
                    vbus.value_ready <= 1'b1;
                    busy             <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_digit_value_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_digit_value_ctrl
// Description : Self-checking bench for digit_value_ctrl (DIGITS=4,
//               VALUE_W=14) with a decimal reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_digit_value_ctrl;

    localparam int DIGITS  = 4;
    localparam int VALUE_W = 14;

    logic                 clk;
    logic                 rst;
    logic                 vblnk_in;
    logic [4*DIGITS-1:0]  digits_out;
    logic [DIGITS-1:0]    digit_en;
    logic                 busy;
    logic                 commit;

    int checks;
    int failures;

    logic [15:0] exp_digits;
    logic [3:0]  exp_en;

    digit_value_ctrl_if #(.VALUE_W(VALUE_W)) vif ();

    digit_value_ctrl #(
        .DIGITS  (DIGITS),
        .VALUE_W (VALUE_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .vbus       (vif.slave),
        .vblnk_in   (vblnk_in),
        .digits_out (digits_out),
        .digit_en   (digit_en),
        .busy       (busy),
        .commit     (commit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: saturate to 9999, then take decimal digits arithmetically.
    function automatic logic [15:0] ref_bcd(input int v);
        int s;
        logic [15:0] r;
        s = (v > 9999) ? 9999 : v;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            r[4*k +: 4] = 4'(s % 10);
            s = s / 10;
        end
        return r;
    endfunction

    function automatic logic [3:0] ref_en(input int v);
        int s;
        int p;
        logic [3:0] e;
        s = (v > 9999) ? 9999 : v;
        e = 4'b0001;
        p = 10;
        for (int k = 1; k < 4; k++) begin
            if (s >= p) e[k] = 1'b1;
            p = p * 10;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_hold(input string tag);
        chk({tag, "_commit"}, 32'(commit), 32'd0);
        chk({tag, "_digits"}, 32'(digits_out), 32'(exp_digits));
        chk({tag, "_en"}, 32'(digit_en), 32'(exp_en));
    endtask

    // Raise vblnk, expect the commit on that edge, then a single pulse.
    task automatic do_commit(input int v, input string tag);
        vblnk_in = 1'b1;
        tick();
        exp_digits = ref_bcd(v);
        exp_en     = ref_en(v);
        chk({tag, "_commit"}, 32'(commit), 32'd1);
        chk({tag, "_digits"}, 32'(digits_out), 32'(exp_digits));
        chk({tag, "_en"}, 32'(digit_en), 32'(exp_en));
        chk({tag, "_ready"}, 32'(vif.value_ready), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        tick();
        chk({tag, "_pulse1"}, 32'(commit), 32'd0);
        vblnk_in = 1'b0;
        tick();
    endtask

    // Accept v with vblnk low; wait 'gap' extra cycles after the conversion.
    // early=1 raises vblnk on the last conversion edge so that edge is missed.
    task automatic run_txn(input int v, input int gap, input bit early, input string tag);
        vif.value_in    = 14'(v);
        vif.value_valid = 1'b1;
        tick();
        vif.value_valid = 1'b0;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_ready"}, 32'(vif.value_ready), 32'd0);
        for (int i = 1; i <= VALUE_W; i++) begin
            if (i == VALUE_W && early) vblnk_in = 1'b1;
            tick();
            expect_hold({tag, "_conv"});
        end
        if (early) begin
            tick();
            expect_hold({tag, "_early"});
            chk({tag, "_early_busy"}, 32'(busy), 32'd1);
            vblnk_in = 1'b0;
            tick();
            expect_hold({tag, "_low"});
        end
        for (int i = 0; i < gap; i++) begin
            tick();
            expect_hold({tag, "_gap"});
        end
        do_commit(v, tag);
    endtask

    initial begin
        int v;
        checks          = 0;
        failures        = 0;
        exp_digits      = 16'h0000;
        exp_en          = 4'b0001;
        rst             = 1'b1;
        vblnk_in        = 1'b0;
        vif.value_in    = '0;
        vif.value_valid = 1'b0;

        tick();
        chk("rst_digits", 32'(digits_out), 32'h0);
        chk("rst_en", 32'(digit_en), 32'b0001);
        chk("rst_ready", 32'(vif.value_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_commit", 32'(commit), 32'd0);
        rst = 1'b0;
        tick();

        run_txn(1234, 2, 1'b0, "v1234");
        chk("v1234_lit", 32'(digits_out), 32'h1234);
        run_txn(7, 0, 1'b0, "v7");
        chk("v7_lit_en", 32'(digit_en), 32'b0001);
        run_txn(0, 1, 1'b0, "v0");
        run_txn(12000, 1, 1'b0, "v12000");
        chk("v12000_lit", 32'(digits_out), 32'h9999);
        run_txn(9999, 0, 1'b1, "v9999");

        // vblnk high across the whole conversion: needs a fresh rising edge.
        vblnk_in        = 1'b1;
        vif.value_in    = 14'd50;
        vif.value_valid = 1'b1;
        tick();
        vif.value_valid = 1'b0;
        for (int i = 0; i < VALUE_W + 6; i++) begin
            tick();
            expect_hold("v50_high");
        end
        vblnk_in = 1'b0;
        tick();
        tick();
        expect_hold("v50_low");
        do_commit(50, "v50");
        chk("v50_lit_en", 32'(digit_en), 32'b0011);

        // 321 accepted, then 999 offered continuously while busy.
        vif.value_in    = 14'd321;
        vif.value_valid = 1'b1;
        tick();
        vif.value_in = 14'd999;
        for (int i = 0; i < VALUE_W + 2; i++) begin
            tick();
            expect_hold("v321_busy");
            chk("v321_ready", 32'(vif.value_ready), 32'd0);
        end
        vblnk_in = 1'b1;
        tick();
        exp_digits = ref_bcd(321);
        exp_en     = ref_en(321);
        chk("v321_commit", 32'(commit), 32'd1);
        chk("v321_digits", 32'(digits_out), 32'(exp_digits));
        chk("v321_busy_e", 32'(busy), 32'd0);
        tick();
        chk("v999_accept", 32'(busy), 32'd1);
        vif.value_valid = 1'b0;
        vblnk_in        = 1'b0;
        for (int i = 0; i < VALUE_W; i++) begin
            tick();
            expect_hold("v999_conv");
        end
        do_commit(999, "v999");

        // Randomized values against the decimal model.
        for (int n = 0; n < 8; n++) begin
            v = int'($urandom_range(0, 16383));
            run_txn(v, int'($urandom_range(0, 4)), 1'b0, "rand");
        end

        // Asynchronous reset in the middle of a conversion.
        vif.value_in    = 14'd4321;
        vif.value_valid = 1'b1;
        tick();
        vif.value_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        #2;
        rst = 1'b1;
        #1;
        exp_digits = 16'h0000;
        exp_en     = 4'b0001;
        chk("arst_digits", 32'(digits_out), 32'h0);
        chk("arst_en", 32'(digit_en), 32'b0001);
        chk("arst_ready", 32'(vif.value_ready), 32'd1);
        chk("arst_busy", 32'(busy), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        run_txn(88, 1, 1'b0, "v88");
        chk("v88_lit", 32'(digits_out), 32'h0088);
        chk("v88_lit_en", 32'(digit_en), 32'b0011);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/digit_value_ctrl.md
# digit_value_ctrl

Frame-synchronous controller that feeds a row of single-digit display units on the status overlay. It accepts a binary value through a valid/ready handshake and converts it to BCD sequentially, using one double-dabble iteration per clock. Each digit unit gets a 4-bit digit and a leading-zero enable. The displayed digits change only on the rising edge of vertical blanking, so a value never tears mid-frame. It sits in the status pipeline ahead of the digit-drawing chain; digit k (k=0 is least significant) drives the digit input of the k-th drawing unit.

## Interface
- DIGITS, 4, number of decimal digits driven (1..4)
- VALUE_W, 14, width of the binary input value (1..16)

- clk  in  1  pixel clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- value_in  in  VALUE_W  unsigned binary value to display
- value_valid  in  1  value_in is valid this cycle
- value_ready  out  1  high only in IDLE; a transfer occurs when valid and ready are both high
- vblnk_in  in  1  vertical blanking from the timing chain
- digits_out  out  4*DIGITS  BCD digits; bits [4k+3:4k] are digit k
- digit_en  out  DIGITS  bit k high if digit k is displayed (leading-zero blanking)
- busy  out  1  high in CONV and WAIT_VB
- commit  out  1  one-cycle pulse on the cycle digits_out updates

## Operation
- Reset values: state IDLE, value_ready 1, busy 0, commit 0, digits_out 0, digit_en = 1 (bit 0 only), edge register vblnk_d 0, counters 0.
- Saturation at accept: let MAX = 10^DIGITS-1. If value_in > MAX, the loaded value is MAX (all nines). If MAX is not representable in VALUE_W bits, no saturation is applied.
- Working register: 4*DIGITS BCD bits concatenated with a VALUE_W binary part. At accept, BCD = 0 and binary = the loaded value.
- FSM:
  - IDLE: on valid & ready, load the working register, clear the iteration counter, go to CONV.
  - CONV: each cycle, add 3 to every BCD nibble ≥5, then shift the whole register left by 1, and increment the counter. After the VALUE_W-th iteration, go to WAIT_VB.
  - WAIT_VB: hold the BCD result. When vblnk_in & ~vblnk_d (rising edge) is seen, load digits_out and digit_en, pulse commit, and go to IDLE.
- vblnk_d registers vblnk_in every cycle regardless of state. A rising edge seen in IDLE or CONV is ignored (not remembered).
- digit_en[0] = 1. For k>0, digit_en[k] = 1 if any of digits k..DIGITS-1 is nonzero. It is computed from the new result and registered together with digits_out.
- value_valid while busy: ignored, no transfer, and the value is not queued.
- digits_out and digit_en hold their last committed values at all other times.

## Timing
- The accept edge is T. CONV occupies cycles T+1 .. T+VALUE_W. WAIT_VB is entered at edge T+VALUE_W.
- Commit is on the first clock edge E ≥ T+VALUE_W+1 where vblnk_in=1 and vblnk_d=0 at E. digits_out, digit_en and commit change at E. value_ready returns to 1 and busy to 0 at E.
- Minimum accept-to-display: VALUE_W+1 cycles. Maximum: that plus one frame.
- If vblnk_in is already high when WAIT_VB is entered, the commit waits for the next frame's rising edge.
- Back-to-back: the next accept is possible on the edge after E.
- Reset mid-operation (any state): everything returns to reset values immediately. The partial conversion is discarded and digits_out goes to 0.

## Test plan
- DIGITS=4, VALUE_W=14. Hold vblnk low, accept 1234, wait >14 cycles, raise vblnk. Required: digits_out=0x1234 and digit_en=4'b1111 at the rising-edge clock, with a single commit pulse. Before that edge, digits_out stays 0x0000.
- Accept 7. Required: after the edge, digits_out=0x0007 and digit_en=4'b0001. Then accept 0. Required: digits_out=0x0000 and digit_en=4'b0001.
- Accept 12000. Required: digits_out=0x9999 and digit_en=4'b1111. Accept 9999. Required: 0x9999 and busy exactly 14 cycles before WAIT_VB.
- Accept 50 while vblnk_in is high and stays high through the conversion. Required: no update until vblnk falls and rises again, then digits_out=0x0050 and digit_en=4'b0011.
- Accept 321, then assert value_valid with 999 every cycle while busy. Required: value_ready low, 321 displayed, 999 accepted only on the cycle after commit.
- Assert rst at CONV iteration 5 of value 4321. Required: digits_out=0, digit_en=0001 and value_ready=1 immediately. A new accept of 88 after release yields 0x0088.
